// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for the single-port data RAM: port 0 (CPU) and port 1 (DMA/debug).
// Pipeline: ARB (combinational grant, latch at accept) -> ACCESS (drive RAM) -> done/rdata stage.
module ram_arbiter #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter logic [15:0] P1_WP_BASE = 16'h0100,
  parameter logic [15:0] P1_WP_LAST = 16'h01FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [15:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic [7:0]  p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [15:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic [7:0]  p1_rdata,
  output logic        p1_err,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data_in,
  output logic        ram_write_enable,
  output logic        ram_read_enable,
  input  logic [7:0]  ram_data_out,
  input  logic        ram_ready,
  output logic        busy
);

  function automatic logic wp_hit(input logic [15:0] a);
    return (a >= P1_WP_BASE) && (a <= P1_WP_LAST);
  endfunction

  logic        last_p0;
  logic        accept_p0;
  logic        vld_p1;
  logic        port_p1;
  logic        we_p1;
  logic        hit_p1;
  logic [15:0] addr_p1;
  logic [7:0]  wdata_p1;
  logic        act_p1;

  // ARB stage: grant is independent of ACCESS so back-to-back accepts are possible
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (ram_ready && !reset) begin
      p0_gnt = p0_req && (!p1_req || FIXED_PRIO || !last_p0);
      p1_gnt = p1_req && !p0_gnt;
    end
  end

  assign accept_p0 = p0_gnt || p1_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p1 <= accept_p0;
      if (accept_p0) last_p0 <= p0_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_p0) begin
      port_p1  <= p1_gnt;
      we_p1    <= p1_gnt ? p1_we    : p0_we;
      addr_p1  <= p1_gnt ? p1_addr  : p0_addr;
      wdata_p1 <= p1_gnt ? p1_wdata : p0_wdata;
      hit_p1   <= p1_gnt && p1_we && wp_hit(p1_addr);
    end
  end

  // ACCESS stage: reset masks the RAM lines so an in-flight write is dropped
  assign act_p1           = vld_p1 && !reset;
  assign ram_addr         = act_p1 ? addr_p1 : 16'h0000;
  assign ram_data_in      = (act_p1 && we_p1) ? wdata_p1 : 8'h00;
  assign ram_write_enable = act_p1 && we_p1 && !hit_p1;
  assign ram_read_enable  = act_p1 && !we_p1;
  assign busy             = vld_p1;

  // Completion stage: done/err pulse, read data captured from the async RAM output
  always_ff @(posedge clk) begin
    if (reset) begin
      p0_done  <= 1'b0;
      p1_done  <= 1'b0;
      p1_err   <= 1'b0;
      p0_rdata <= 8'h00;
      p1_rdata <= 8'h00;
    end else begin
      p0_done <= vld_p1 && !port_p1;
      p1_done <= vld_p1 && port_p1;
      p1_err  <= vld_p1 && port_p1 && hit_p1;
      if (vld_p1 && !we_p1 && !port_p1) p0_rdata <= ram_data_out;
      if (vld_p1 && !we_p1 && port_p1)  p1_rdata <= ram_data_out;
    end
  end

  assign p0_err = 1'b0;

endmodule
